// File: rtl/pc_seq_pkg.sv
// ============================================================================
// Module      : pc_seq_pkg
// Description : Shared pc_src encodings and default vectors for pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_seq_pkg;

    localparam logic [2:0] PCSRC_SEQ  = 3'b000;
    localparam logic [2:0] PCSRC_BR   = 3'b001;
    localparam logic [2:0] PCSRC_J    = 3'b010;
    localparam logic [2:0] PCSRC_JR   = 3'b011;
    localparam logic [2:0] PCSRC_ERET = 3'b100;
    localparam logic [2:0] PCSRC_EXC  = 3'b101;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_IRQ_VEC   = 32'h8000_0004;
    localparam logic [31:0] DEF_EXC_VEC   = 32'h8000_0008;

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_irq_prio_enc.sv
// ============================================================================
// Module      : irq_prio_enc
// Description : Lowest-index-first priority encoder over enabled, unmasked
//               pending interrupts; one-hot ack plus an any flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module irq_prio_enc #(
    parameter int N_IRQ = 4
) (
    input  logic [N_IRQ-1:0] pending,
    input  logic [N_IRQ-1:0] mask,
    input  logic             enable,
    output logic [N_IRQ-1:0] ack,
    output logic             any
);

    logic [N_IRQ-1:0] w_req;

    assign w_req = pending & mask & {N_IRQ{enable}};
    // Two's-complement trick isolates the lowest set bit.
    assign ack   = w_req & (~w_req + N_IRQ'(1));
    assign any   = |w_req;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Registered PC / EPC / kernel-bit sequencer with edge-latched,
//               maskable, prioritised interrupts. Define PC_SEQ_IRQ_SYNC_EN to
//               put a 2-flop synchroniser in front of the irq edge detector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                N_IRQ     = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
    parameter logic [ADDR_W-1:0] IRQ_VEC   = ADDR_W'(DEF_IRQ_VEC),
    parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(DEF_EXC_VEC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [2:0]        pc_src,
    input  logic              branch_taken,
    input  logic [15:0]       br_imm,
    input  logic [25:0]       jump_idx,
    input  logic [ADDR_W-1:0] jr_target,
    input  logic [N_IRQ-1:0]  irq,
    input  logic              mask_we,
    input  logic [N_IRQ-1:0]  mask_wdata,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] epc,
    output logic              kernel,
    output logic              irq_taken,
    output logic [N_IRQ-1:0]  irq_ack
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
    logic [N_IRQ-1:0]  pending_q, pending_d;
    logic [N_IRQ-1:0]  mask_q, mask_d;
    logic [N_IRQ-1:0]  irq_prev_q;
    logic [N_IRQ-1:0]  w_irq_s;

`ifdef PC_SEQ_IRQ_SYNC_EN
    logic [N_IRQ-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq;
            sync2_q <= sync1_q;
        end
    end

    assign w_irq_s = sync2_q;
`else
    assign w_irq_s = irq;
`endif

    logic [ADDR_W-2:0] w_low_plus4;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_br_off;
    logic [ADDR_W-1:0] w_br_sum;
    logic [ADDR_W-1:0] w_br_target;
    logic [ADDR_W-1:0] w_j_target;
    logic              w_enable;

    // Increment stays inside the current half of the address space.
    assign w_low_plus4 = pc_q[ADDR_W-2:0] + (ADDR_W-1)'(4);
    assign w_pc_plus4  = {pc_q[ADDR_W-1], w_low_plus4};
    assign w_br_off    = {{(ADDR_W-18){br_imm[15]}}, br_imm, 2'b00};
    assign w_br_sum    = w_pc_plus4 + w_br_off;
    assign w_br_target = {pc_q[ADDR_W-1], w_br_sum[ADDR_W-2:0]};
    assign w_j_target  = ADDR_W'({w_pc_plus4[ADDR_W-1:ADDR_W-4], jump_idx, 2'b00});

    assign w_enable = ~pc_q[ADDR_W-1] & ~stall & (pc_src != PCSRC_EXC);

    irq_prio_enc #(
        .N_IRQ (N_IRQ)
    ) u_prio (
        .pending (pending_q),
        .mask    (mask_q),
        .enable  (w_enable),
        .ack     (irq_ack),
        .any     (irq_taken)
    );

    always_comb begin
        pc_d  = pc_q;
        epc_d = epc_q;
        if (!stall) begin
            if (pc_src == PCSRC_EXC) begin
                pc_d  = EXC_VEC;
                epc_d = w_pc_plus4;
            end else if (irq_taken) begin
                // Squash: the interrupted instruction re-executes after eret.
                pc_d  = IRQ_VEC;
                epc_d = pc_q;
            end else begin
                case (pc_src)
                    PCSRC_ERET: pc_d = epc_q;
                    PCSRC_JR:   pc_d = jr_target;
                    PCSRC_J:    pc_d = w_j_target;
                    PCSRC_BR:   pc_d = branch_taken ? w_br_target : w_pc_plus4;
                    default:    pc_d = w_pc_plus4;
                endcase
            end
        end
    end

    // A fresh edge on an acked line re-arms it in the same cycle.
    assign pending_d = (pending_q & ~irq_ack) | (w_irq_s & ~irq_prev_q);
    assign mask_d    = mask_we ? mask_wdata : mask_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q       <= RESET_VEC;
            epc_q      <= '0;
            pending_q  <= '0;
            mask_q     <= '1;
            irq_prev_q <= '0;
        end else begin
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            irq_prev_q <= w_irq_s;
        end
    end

    assign pc       = pc_q;
    assign pc_plus4 = w_pc_plus4;
    assign epc      = epc_q;
    assign kernel   = pc_q[ADDR_W-1];

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Scoreboard bench for pc_sequencer: directed flows plus random
//               traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [2:0]  pc_src;
    logic        branch_taken;
    logic [15:0] br_imm;
    logic [25:0] jump_idx;
    logic [31:0] jr_target;
    logic [3:0]  irq;
    logic        mask_we;
    logic [3:0]  mask_wdata;
    logic [31:0] pc, pc_plus4, epc;
    logic        kernel, irq_taken;
    logic [3:0]  irq_ack;

    pc_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .pc_src       (pc_src),
        .branch_taken (branch_taken),
        .br_imm       (br_imm),
        .jump_idx     (jump_idx),
        .jr_target    (jr_target),
        .irq          (irq),
        .mask_we      (mask_we),
        .mask_wdata   (mask_wdata),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .epc          (epc),
        .kernel       (kernel),
        .irq_taken    (irq_taken),
        .irq_ack      (irq_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] epc;
        logic        kern;
        logic        taken;
        logic [3:0]  ack;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [31:0] m_pc, m_epc;
    logic [3:0]  m_pend, m_mask, m_prev;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_epc = 32'h0; m_pend = 4'h0; m_mask = 4'hF; m_prev = 4'h0;
    endtask

    // Predict this cycle's outputs, push them, clock once, commit model state.
    task automatic step();
        exp_t e;
        logic [31:0] p4, npc, nepc, off;
        logic [3:0]  ack, npend;
        int sel;
        int signed v;
        p4  = (m_pc & 32'h8000_0000) | ((m_pc + 32'd4) & 32'h7FFF_FFFF);
        sel = -1;
        if (!m_pc[31] && !stall && pc_src != 3'd5)
            for (int i = 0; i < 4; i++)
                if (sel < 0 && m_pend[i] && m_mask[i]) sel = i;
        ack = (sel >= 0) ? 4'(1 << sel) : 4'd0;
        e.pc = m_pc; e.pc4 = p4; e.epc = m_epc; e.kern = m_pc[31];
        e.taken = (sel >= 0); e.ack = ack;
        npc = m_pc; nepc = m_epc;
        if (!stall) begin
            if (pc_src == 3'd5) begin
                npc = 32'h8000_0008; nepc = p4;
            end else if (sel >= 0) begin
                npc = 32'h8000_0004; nepc = m_pc;
            end else if (pc_src == 3'd4) npc = m_epc;
            else if (pc_src == 3'd3) npc = jr_target;
            else if (pc_src == 3'd2) npc = (p4 & 32'hF000_0000) | (32'(jump_idx) * 4);
            else if (pc_src == 3'd1 && branch_taken) begin
                v   = int'($signed(br_imm));
                off = v * 4;
                npc = (m_pc & 32'h8000_0000) | ((p4 + off) & 32'h7FFF_FFFF);
            end else npc = p4;
        end
        npend = (m_pend & ~ack) | (irq & ~m_prev);
        q.push_back(e);
        @(posedge clk);
        m_pc = npc; m_epc = nepc; m_pend = npend; m_prev = irq;
        if (mask_we) m_mask = mask_wdata;
        #1;
    endtask

    task automatic set_in(input logic [2:0] src, input logic [31:0] jrt);
        pc_src = src; jr_target = jrt;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            me = q.pop_front();
            chk("sb_pc", pc, me.pc);
            chk("sb_pc_plus4", pc_plus4, me.pc4);
            chk("sb_epc", epc, me.epc);
            chk("sb_kernel", 32'(kernel), 32'(me.kern));
            chk("sb_irq_taken", 32'(irq_taken), 32'(me.taken));
            chk("sb_irq_ack", 32'(irq_ack), 32'(me.ack));
        end
    end

    logic [31:0] hold_pc;

    initial begin
        reset = 1'b0; stall = 1'b0; pc_src = 3'd0; branch_taken = 1'b0;
        br_imm = 16'h0; jump_idx = 26'h0; jr_target = 32'h0; irq = 4'h0;
        mask_we = 1'b0; mask_wdata = 4'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_ack", 32'(irq_ack), 32'h0);
        chk("rst_taken", 32'(irq_taken), 32'h0);
        reset = 1'b1;

        // Sequential fetch
        chk("seq0", pc, 32'h0);
        step(); chk("seq1", pc, 32'h4);
        step(); chk("seq2", pc, 32'h8);
        step(); chk("seq3", pc, 32'hC);

        // Branch taken / not taken, jr into wrap, jump in kernel half
        set_in(3'd3, 32'h10); step();
        pc_src = 3'd1; br_imm = 16'hFFFE; branch_taken = 1'b1; step();
        chk("br_taken", pc, 32'h0C);
        set_in(3'd3, 32'h10); step();
        pc_src = 3'd1; branch_taken = 1'b0; step();
        chk("br_not_taken", pc, 32'h14);
        set_in(3'd3, 32'hFFFF_FFFC); step();
        pc_src = 3'd0; step();
        chk("wrap_kernel", pc, 32'h8000_0000);
        set_in(3'd3, 32'h8000_0100); step();
        pc_src = 3'd2; jump_idx = 26'h80; step();
        chk("jump", pc, 32'h8000_0200);

        // IRQ entry, kernel blocking, eret return
        set_in(3'd3, 32'h40); irq = 4'b0100; step();
        pc_src = 3'd0; #1;
        chk("irq_taken", 32'(irq_taken), 32'h1);
        chk("irq_ack2", 32'(irq_ack), 32'h4);
        step();
        chk("irq_pc", pc, 32'h8000_0004);
        chk("irq_epc", epc, 32'h40);
        irq = 4'b0110; step();
        #1; chk("kernel_block", 32'(irq_taken), 32'h0);
        step();
        pc_src = 3'd4; step();
        chk("eret_pc", pc, 32'h40);
        pc_src = 3'd0; #1;
        chk("irq_ack1", 32'(irq_ack), 32'h2);
        step();
        irq = 4'h0; pc_src = 3'd4; step();

        // Mask and priority
        pc_src = 3'd0; mask_we = 1'b1; mask_wdata = 4'b1000; step();
        mask_we = 1'b0; irq = 4'b1001; step();
        #1; chk("mask_prio", 32'(irq_ack), 32'h8);
        step();
        irq = 4'h0; pc_src = 3'd4; step();
        pc_src = 3'd0; mask_we = 1'b1; mask_wdata = 4'b1111; #1;
        chk("mask_not_yet", 32'(irq_taken), 32'h0);
        step();
        mask_we = 1'b0; #1;
        chk("mask_now", 32'(irq_ack), 32'h1);
        step();
        pc_src = 3'd4; step();

        // Stall holds PC and blocks the take, pending survives
        pc_src = 3'd0; stall = 1'b1; irq = 4'b0010; hold_pc = pc; step();
        #1; chk("stall_taken", 32'(irq_taken), 32'h0);
        step();
        chk("stall_pc", pc, hold_pc);
        stall = 1'b0; #1;
        chk("stall_release", 32'(irq_ack), 32'h2);
        step();
        irq = 4'h0; pc_src = 3'd4; step();

        // Exception beats a pending interrupt
        set_in(3'd3, 32'h20); irq = 4'b0100; step();
        pc_src = 3'd5; #1;
        chk("exc_ack", 32'(irq_ack), 32'h0);
        step();
        chk("exc_pc", pc, 32'h8000_0008);
        chk("exc_epc", epc, 32'h24);
        irq = 4'h0; pc_src = 3'd4; step();
        pc_src = 3'd0; step(); step();

        // Asynchronous reset mid-flight drops pending edges
        irq = 4'b0001; pc_src = 3'd4; step();
        #1; reset = 1'b0; #1;
        model_reset();
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_epc", epc, 32'h0);
        @(posedge clk); #1;
        irq = 4'h0; reset = 1'b1;
        pc_src = 3'd0; step(); step();

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            int r;
            r = $urandom % 16;
            stall        = ($urandom % 6) == 0;
            pc_src       = (r < 7) ? 3'd0 : (r < 9) ? 3'd1 : (r < 10) ? 3'd2 :
                           (r < 11) ? 3'd3 : (r < 13) ? 3'd4 : (r < 14) ? 3'd5 : 3'(r - 8);
            branch_taken = $urandom % 2;
            br_imm       = 16'($urandom);
            jump_idx     = 26'($urandom);
            jr_target    = $urandom;
            if ($urandom % 3 == 0) irq = 4'($urandom);
            mask_we      = ($urandom % 12) == 0;
            mask_wdata   = 4'($urandom);
            step();
        end

        stall = 1'b0; pc_src = 3'd0; mask_we = 1'b0;
        @(negedge clk); #1;
        chk("sb_drained", 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter and interrupt/exception sequencer for the MIPS core.
- Replaces the flat next-PC mux and the tied-off IRQ with a registered PC, an EPC register and a kernel-mode bit.
- Adds N_IRQ edge-latched, maskable, prioritised interrupt lines, plus stall and eret support.
- Sits between Control, the register file (jr source) and InstructionMemory (drives its Address).

Parameters:
- ADDR_W, 32: PC/EPC width; bit ADDR_W-1 is the kernel bit.
- N_IRQ, 4: number of interrupt lines.
- RESET_VEC, 32'h0000_0000: PC after reset.
- IRQ_VEC, 32'h8000_0004: interrupt entry.
- EXC_VEC, 32'h8000_0008: exception (undefined-instruction) entry.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- stall  in  1  hold PC this cycle
- pc_src  in  3  000 seq, 001 branch, 010 jump, 011 jr, 100 eret, 101 exception, 11x treated as seq
- branch_taken  in  1  branch condition (ALU outZ[0])
- br_imm  in  16  raw branch immediate
- jump_idx  in  26  J-type index
- jr_target  in  ADDR_W  rs value for jr/jalr
- irq  in  N_IRQ  level interrupt requests
- mask_we  in  1  write irq mask
- mask_wdata  in  N_IRQ  new mask (1 = enabled)
- pc  out  ADDR_W  current PC
- pc_plus4  out  ADDR_W  {pc[ADDR_W-1], (pc+4)[ADDR_W-2:0]}
- epc  out  ADDR_W  saved return address
- kernel  out  1  pc[ADDR_W-1]
- irq_taken  out  1  combinational; squash current instruction this cycle
- irq_ack  out  N_IRQ  one-hot of line being taken, combinational

Behaviour:
- Reset values: pc=RESET_VEC, epc=0, pending=0, mask=all ones, irq_prev=0. Hence irq_taken=0 and irq_ack=0.
- Arithmetic:
  - pc_plus4 never changes the kernel bit; it wraps inside its half of the address space.
  - Branch target = pc_plus4 + (sext(br_imm)<<2), with the kernel bit forced to pc[ADDR_W-1].
  - Jump target = {pc_plus4[ADDR_W-1:ADDR_W-4], jump_idx, 2'b00}.
- Pending capture runs every cycle, including under stall:
  - irq_prev <= irq.
  - pending[i] set on irq[i] & ~irq_prev[i].
  - pending[i] cleared when irq_ack[i].
  - A new rising edge in the same cycle as the ack wins (pending stays 1).
- Mask: mask_we updates mask on the edge. The new mask affects selection from the next cycle. Masked pending bits are retained.
- Selection: take = pending & mask & ~kernel & ~stall & (pc_src != 101). The lowest index wins; irq_ack is that one-hot, and irq_taken = |take.
- Next-state priority:
  1. stall: pc and epc hold.
  2. pc_src==101: pc<=EXC_VEC, epc<=pc_plus4. This is legal in kernel mode and overwrites epc.
  3. irq_taken: pc<=IRQ_VEC, epc<=pc. The current instruction is squashed and re-executed after eret.
  4. eret: pc<=epc.
  5. jr: pc<=jr_target (may change the kernel bit).
  6. jump.
  7. branch: target if branch_taken, else pc_plus4.
  8. seq: pc_plus4.
- Latency:
  - An irq edge sampled at edge k sets pending at k.
  - The earliest take is the cycle after k; the PC reaches IRQ_VEC at edge k+1 (user mode, no stall).
- Kernel mode blocks interrupts. Interrupts pending on entry are taken on the first user-mode cycle after eret.
- Reset asserted mid-operation returns all state to reset values asynchronously. Pending edges are lost.

Optional Feature:
- Macro PC_SEQ_IRQ_SYNC_EN.
- Defined: irq passes through a 2-flop synchroniser (reset 0) before edge detection. Take latency grows by 2 cycles.
- Undefined: irq is used directly; the source must be synchronous to clk.

Decomposition:
- Shared package pc_seq_pkg holds:
  - PCSRC_SEQ/BR/J/JR/ERET/EXC 3-bit localparams.
  - Default vector constants.
- Sub-module irq_prio_enc: combinational N_IRQ lowest-index-first priority encoder. Inputs: pending, mask, enable. Outputs: one-hot ack and any.

Test Plan:
1. Reset low, then release; seq for 3 cycles -> pc 0x0, 0x4, 0x8, 0xC; epc=0; irq_ack=0.
2. Branch and wrap:
   - pc=0x10, br_imm=0xFFFE, taken -> 0x0C; not taken -> 0x14.
   - jr to 0xFFFFFFFC then seq -> 0x80000000 (kernel bit kept).
3. Jump: pc=0x80000100, jump_idx=0x80 -> 0x80000200.
4. IRQ flow:
   - pc=0x40 user, irq[2] rises -> next cycle irq_taken=1, irq_ack=0100; pc=0x80000004, epc=0x40.
   - irq[1] rises in kernel -> not taken.
   - eret -> pc=0x40, then irq_ack=0010.
5. Mask/priority:
   - mask=1000, irq[0] and irq[3] rise together -> irq[3] taken first.
   - After eret, write mask=1111 -> irq[0] taken.
6. Stall/exception:
   - Stall with pending enabled irq -> pc holds, irq_taken=0, pending kept.
   - pc=0x20, pc_src=101 with pending irq -> pc=0x80000008, epc=0x24, irq_ack=0.
